// File: rtl/mem_sp_sky130_rmw_if.sv
// Request/response bundle for mem_sp_sky130_rmw: valid/ready request side plus
// the registered read-return strobe and data.
interface mem_sp_sky130_rmw_if #(
  parameter int DATA_BIT = 32,
  parameter int ADDR_BIT = 7
);
  logic [ADDR_BIT-1:0] addr;
  logic                wen;
  logic                ren;
  logic [DATA_BIT-1:0] bwe;
  logic [DATA_BIT-1:0] wdata;
  logic                ready;
  logic                rvalid;
  logic [DATA_BIT-1:0] rdata;

  modport master (output addr, wen, ren, bwe, wdata, input ready, rvalid, rdata);
  modport slave  (input addr, wen, ren, bwe, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/mem_sp_sky130_rmw.sv
// Single-port SRAM wrapper tiling 32x128 sky130 1RW macros in depth and width.
// Define MEM_SKY130_RMW_EN to build the read-modify-write sequencer for bit-masked writes.

// Behavioural stand-in for the hard macro: inputs sampled on the rising edge,
// dout0 updated only by a read and held otherwise.
module sky130_sram_0kbytes_1rw_32x128_32_used (
  input  logic        clk0,
  input  logic        csb0,
  input  logic        web0,
  input  logic [6:0]  addr0,
  input  logic [31:0] din0,
  output logic [31:0] dout0
);
  logic [31:0] mem_q [128];

  always_ff @(posedge clk0) begin
    if (!csb0) begin
      if (!web0) mem_q[addr0] <= din0;
      else       dout0        <= mem_q[addr0];
    end
  end
endmodule

module mem_sp_sky130_rmw #(
  parameter int DATA_BIT = 32,
  parameter int DEPTH    = 128,
  parameter int ADDR_BIT = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input logic              clk,
  input logic              rst,
  mem_sp_sky130_rmw_if.slave bus
);
  localparam int NUM_BANKS = (DATA_BIT + 31) / 32;
  localparam int NUM_TILES = (DEPTH + 127) / 128;
  localparam int PAD_W     = NUM_BANKS * 32;
  localparam int TILE_W    = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

  logic [31:0]       addr_ext;
  logic [TILE_W-1:0] tile_w;
  logic [6:0]        local_w;
  logic              oor_w;
  logic              accept;
  logic              rd_acc;
  logic [PAD_W-1:0]  wdata_pad;

  assign addr_ext  = 32'(bus.addr);
  assign tile_w    = TILE_W'(addr_ext >> 7);
  assign local_w   = addr_ext[6:0];
  assign oor_w     = (addr_ext >= 32'(DEPTH));
  assign accept    = bus.ready & (bus.wen | bus.ren) & ~rst;
  assign rd_acc    = accept & bus.ren & ~bus.wen;
  assign wdata_pad = PAD_W'(bus.wdata);

  logic              mem_cs;
  logic              mem_we;
  logic [TILE_W-1:0] mem_tile;
  logic [6:0]        mem_addr;
  logic [PAD_W-1:0]  mem_din;
  logic [31:0]       dout_w [NUM_TILES][NUM_BANKS];

  // Read pipeline: tile/oor travel with the macro access into the return mux
  logic              vld_p1_q;
  logic [TILE_W-1:0] tile_p1_q;
  logic              oor_p1_q;
  logic              rvalid_q;
  logic [DATA_BIT-1:0] rdata_q;
  logic [PAD_W-1:0]  rd_word;

`ifdef MEM_SKY130_RMW_EN
  typedef enum logic [1:0] {S_IDLE, S_MERGE, S_WRITE} state_t;
  state_t            state_q;
  logic [PAD_W-1:0]  wdata_q;
  logic [PAD_W-1:0]  bwe_q;
  logic [PAD_W-1:0]  merged_q;
  logic [6:0]        local_q;
  logic [TILE_W-1:0] tile_q;
  logic              full_w;
  logic              part_w;

  assign full_w    = &bus.bwe;
  assign part_w    = (|bus.bwe) & ~full_w;
  assign bus.ready = (state_q == S_IDLE);

  always_comb begin
    mem_cs   = 1'b0;
    mem_we   = 1'b0;
    mem_tile = tile_w;
    mem_addr = local_w;
    mem_din  = wdata_pad;
    if (state_q == S_WRITE) begin
      mem_cs   = 1'b1;
      mem_we   = 1'b1;
      mem_tile = tile_q;
      mem_addr = local_q;
      mem_din  = merged_q;
    end else if (accept && !oor_w) begin
      if (bus.wen) begin
        // A partial write starts with a plain macro read of the target word
        mem_cs = full_w | part_w;
        mem_we = full_w;
      end else begin
        mem_cs = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept && bus.wen && !oor_w && part_w) begin
            state_q <= S_MERGE;
            wdata_q <= wdata_pad;
            bwe_q   <= PAD_W'(bus.bwe);
            local_q <= local_w;
            tile_q  <= tile_w;
          end
        end
        S_MERGE: begin
          merged_q <= (rd_word & ~bwe_q) | (wdata_q & bwe_q);
          state_q  <= S_WRITE;
        end
        S_WRITE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
`else
  logic unused_bwe;
  assign unused_bwe = ^bus.bwe;
  assign bus.ready  = 1'b1;

  always_comb begin
    mem_cs   = accept & ~oor_w;
    mem_we   = bus.wen;
    mem_tile = tile_w;
    mem_addr = local_w;
    mem_din  = wdata_pad;
  end
`endif

  for (genvar t = 0; t < NUM_TILES; t++) begin : g_tile
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      sky130_sram_0kbytes_1rw_32x128_32_used u_macro (
        .clk0  (clk),
        .csb0  (~(mem_cs & (mem_tile == TILE_W'(t)))),
        .web0  (~mem_we),
        .addr0 (mem_addr),
        .din0  (mem_din[b*32 +: 32]),
        .dout0 (dout_w[t][b])
      );
    end
  end

  always_comb begin
    rd_word = '0;
    for (int t = 0; t < NUM_TILES; t++) begin
      if (tile_p1_q == TILE_W'(t)) begin
        for (int b = 0; b < NUM_BANKS; b++) rd_word[b*32 +: 32] = dout_w[t][b];
      end
    end
  end

  logic unused_rd;
  assign unused_rd = ^rd_word;

  // Stage p1: macro dout valid; capture into rdata before any RMW reuse of dout0
  always_ff @(posedge clk) begin
    if (accept) begin
      tile_p1_q <= tile_w;
      oor_p1_q  <= oor_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      vld_p1_q <= rd_acc;
      rvalid_q <= vld_p1_q;
      if (vld_p1_q) rdata_q <= oor_p1_q ? '0 : rd_word[DATA_BIT-1:0];
    end
  end

  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
endmodule

// File: tb/tb_mem_sp_sky130_rmw.sv
// Directed bench for mem_sp_sky130_rmw at DATA_BIT=64, DEPTH=300 (3 tiles x 2 banks).
module tb_mem_sp_sky130_rmw;
  localparam int DW = 64;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_sp_sky130_rmw_if #(.DATA_BIT(DW), .ADDR_BIT(AW)) bus ();

  mem_sp_sky130_rmw #(.DATA_BIT(DW), .DEPTH(300), .ADDR_BIT(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wen;
    logic          ren;
    logic [DW-1:0] wdata;
    logic [DW-1:0] bwe;
    logic          exp_rv;
    logic [DW-1:0] exp_rd;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  localparam logic [DW-1:0] ONES = {DW{1'b1}};
  localparam logic [DW-1:0] PAT  = 64'hA5A5_0000_0000_0000;

`ifdef MEM_SKY130_RMW_EN
  localparam logic [DW-1:0] P_WD  = 64'h0;
  localparam logic [DW-1:0] P_BW  = 64'h0000_00FF_0000_FF00;
  localparam logic [DW-1:0] P_EXP = 64'hFFFF_FF00_FFFF_00FF;
  localparam logic          P_RDY = 1'b0;
`else
  localparam logic [DW-1:0] P_WD  = 64'h0000_0000_0000_00AB;
  localparam logic [DW-1:0] P_BW  = 64'h0000_0000_0000_00FF;
  localparam logic [DW-1:0] P_EXP = 64'h0000_0000_0000_00AB;
  localparam logic          P_RDY = 1'b1;
`endif

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [AW-1:0] a, input logic w, input logic r,
                       input logic [DW-1:0] d, input logic [DW-1:0] m);
    bus.addr = a; bus.wen = w; bus.ren = r; bus.wdata = d; bus.bwe = m;
  endtask

  task automatic idle();
    bus.wen = 1'b0; bus.ren = 1'b0;
  endtask

  task automatic full_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(a, 1'b1, 1'b0, d, ONES);
    step();
    idle();
  endtask

  task automatic read_check(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    drive(a, 1'b0, 1'b1, '0, '0);
    step();
    idle();
    step();
    chk({name, "_rvalid"}, DW'(bus.rvalid), DW'(1));
    chk({name, "_rdata"}, bus.rdata, exp);
  endtask

  initial begin
    vecs[0]  = '{9'd0,   1, 0, PAT + 64'd0, ONES, 0, '0};
    vecs[1]  = '{9'd1,   1, 0, PAT + 64'd1, ONES, 0, '0};
    vecs[2]  = '{9'd2,   1, 0, PAT + 64'd2, ONES, 0, '0};
    vecs[3]  = '{9'd3,   1, 0, PAT + 64'd3, ONES, 0, '0};
    vecs[4]  = '{9'd130, 1, 0, 64'hDEADBEEF_CAFEF00D, ONES, 0, '0};
    vecs[5]  = '{9'd300, 1, 0, 64'h1111, ONES, 0, '0};
    vecs[6]  = '{9'd7,   1, 1, 64'h1234, ONES, 0, '0};
    vecs[7]  = '{9'd130, 0, 1, '0, '0, 1, 64'hDEADBEEF_CAFEF00D};
    vecs[8]  = '{9'd2,   0, 1, '0, '0, 1, PAT + 64'd2};
    vecs[9]  = '{9'd7,   0, 1, '0, '0, 1, 64'h1234};
    vecs[10] = '{9'd300, 0, 1, '0, '0, 1, 64'h0};
    vecs[11] = '{9'd299, 1, 0, 64'h0123_4567_89AB_CDEF, ONES, 0, '0};
    vecs[12] = '{9'd299, 0, 1, '0, '0, 1, 64'h0123_4567_89AB_CDEF};

    drive('0, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    step();
    step();
    chk("rst_ready", DW'(bus.ready), DW'(1));
    chk("rst_rvalid", DW'(bus.rvalid), DW'(0));
    chk("rst_rdata", bus.rdata, '0);
    rst = 1'b0;
    step();

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].addr, vecs[i].wen, vecs[i].ren, vecs[i].wdata, vecs[i].bwe);
      chk($sformatf("v%0d_ready", i), DW'(bus.ready), DW'(1));
      step();
      idle();
      chk($sformatf("v%0d_rvalid_t1", i), DW'(bus.rvalid), DW'(0));
      step();
      chk($sformatf("v%0d_rvalid_t2", i), DW'(bus.rvalid), DW'(vecs[i].exp_rv));
      if (vecs[i].exp_rv) chk($sformatf("v%0d_rdata", i), bus.rdata, vecs[i].exp_rd);
    end

    // Back-to-back reads of 0..3: rvalid on four consecutive cycles
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive(AW'(i), 1'b0, 1'b1, '0, '0);
      else idle();
      if (i >= 2 && i < 6) begin
        chk($sformatf("b2b%0d_rvalid", i - 2), DW'(bus.rvalid), DW'(1));
        chk($sformatf("b2b%0d_rdata", i - 2), bus.rdata, PAT + DW'(i - 2));
      end
      if (i == 6) chk("b2b_rvalid_end", DW'(bus.rvalid), DW'(0));
      step();
    end

    // Masked write to 5, preceded by a read of 2 issued the cycle before
    full_write(9'd5, ONES);
    drive(9'd2, 1'b0, 1'b1, '0, '0);
    step();
    drive(9'd5, 1'b1, 1'b0, P_WD, P_BW);
    chk("pw_ready_t0", DW'(bus.ready), DW'(1));
    step();
    idle();
    chk("pw_ready_t1", DW'(bus.ready), DW'(P_RDY));
    chk("pw_prior_rvalid", DW'(bus.rvalid), DW'(1));
    chk("pw_prior_rdata", bus.rdata, PAT + 64'd2);
    step();
    chk("pw_ready_t2", DW'(bus.ready), DW'(P_RDY));
    chk("pw_rvalid_t2", DW'(bus.rvalid), DW'(0));
    step();
    chk("pw_ready_t3", DW'(bus.ready), DW'(1));
    read_check("pw_read5", 9'd5, P_EXP);

    // Reset flushes a read in flight
    drive(9'd130, 1'b0, 1'b1, '0, '0);
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("flush_rvalid", DW'(bus.rvalid), DW'(0));
    chk("flush_ready", DW'(bus.ready), DW'(1));
    chk("flush_rdata", bus.rdata, '0);
    step();
    chk("flush_rvalid_t2", DW'(bus.rvalid), DW'(0));
    read_check("post_rst_read130", 9'd130, 64'hDEADBEEF_CAFEF00D);

`ifdef MEM_SKY130_RMW_EN
    // Reset during MERGE discards the masked write
    full_write(9'd9, 64'h55);
    drive(9'd9, 1'b1, 1'b0, 64'hAA, 64'hFF);
    step();
    idle();
    chk("mrst_ready_merge", DW'(bus.ready), DW'(0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_ready", DW'(bus.ready), DW'(1));
    chk("mrst_rvalid", DW'(bus.rvalid), DW'(0));
    step();
    read_check("mrst_read9", 9'd9, 64'h55);
`else
    full_write(9'd9, 64'h55);
    drive(9'd9, 1'b1, 1'b0, 64'hAA, 64'hFF00);
    chk("nrmw_ready_t0", DW'(bus.ready), DW'(1));
    step();
    idle();
    chk("nrmw_ready_t1", DW'(bus.ready), DW'(1));
    read_check("nrmw_read9", 9'd9, 64'hAA);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_sp_sky130_rmw.md
# mem_sp_sky130_rmw

Parametrised single-port SRAM wrapper built from `sky130_sram_0kbytes_1rw_32x128_32_used` macros (32 b x 128 words, 1RW, no write mask). It tiles macros in depth and banks them in width for any `DATA_BIT`/`DEPTH`. It adds a valid/ready request handshake, a registered read-valid strobe, out-of-range protection and bit-granular partial writes via an internal read-modify-write sequencer. It replaces the fixed-behaviour SRAM wrapper in the HW_NOV buffer and weight memories.

## Interface

- `DATA_BIT`, default 32: data width. Any value ≥ 1; `NUM_BANKS = ceil(DATA_BIT/32)`; the top bank is zero-padded.
- `DEPTH`, default 128: words. Any value ≥ 1; `NUM_TILES = ceil(DEPTH/128)`.
- `ADDR_BIT`, default `max(1, $clog2(DEPTH))`: address width.
- `clk` in 1: single clock; the macro and all wrapper flops are on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `addr` in `ADDR_BIT`: word address.
- `wen` in 1: write request, active high.
- `ren` in 1: read request, active high.
- `bwe` in `DATA_BIT`: per-bit write enable, 1 = write the bit.
- `wdata` in `DATA_BIT`: write data.
- `ready` out 1: a request is accepted in any cycle where `ready & (wen | ren)`.
- `rvalid` out 1: one-cycle strobe; `rdata` is valid in that cycle.
- `rdata` out `DATA_BIT`: registered read data; it holds its value until the next `rvalid`.

## Operation

- Address decode: `tile = addr / 128` and `local = addr % 128`. Only the selected tile's macros get `csb0 = 0`. All macros are deselected in cycles with no access.
- Write priority: if `wen` and `ren` are both high, only the write is performed and no `rvalid` is produced.
- Full write (`bwe` all ones): single cycle, all banks of the tile get `web0 = 0`.
- Empty write (`bwe` all zeros): accepted, with no macro access.
- Partial write (any other `bwe`): handled by the RMW FSM.
  - `IDLE`: accept the request, issue a macro read of `addr`, latch `addr/wdata/bwe`, go to `MERGE`.
  - `MERGE`: `merged = (dout & ~bwe) | (wdata & bwe)`, registered, go to `WRITE`.
  - `WRITE`: write `merged` to all banks of the tile, go to `IDLE`.
  - `ready = (state == IDLE)`. The FSM's internal read never produces `rvalid`.
- Out-of-range (`addr >= DEPTH`): the request is accepted. A write is dropped with no macro enabled. A read returns 0 with normal `rvalid` timing.
- Read return: the tile select and an out-of-range flag are pipelined alongside the macro access. The output mux selects the issuing tile's `dout0` and drops the pad bits.
- Back-to-back reads are permitted, one per cycle, at full throughput.

## Timing

- Reset values: `ready = 1`, `rvalid = 0`, `rdata = 0`, FSM = `IDLE`, all macro `csb0 = 1`.
- Read accepted in cycle T: `rvalid = 1` and `rdata` valid in cycle T+2.
- Full write accepted in T: the data is in the array for a read accepted in T+1 or later.
- Partial write accepted in T:
  - `ready = 0` in T+1 and T+2.
  - The next request can be accepted in T+3.
  - A read accepted in T+3 returns the merged word.
- A read accepted in T-1 still returns its `rvalid` in T+1 even if a partial write is accepted in T. Macro `dout0` is captured into the read path before the RMW read reuses it.
- `rst` asserted in any cycle:
  - Next cycle: FSM `IDLE`, `ready = 1`, and the pipeline flushed, so no `rvalid` comes from pre-reset reads.
  - An RMW write not yet in `WRITE` is discarded, and the old word is retained.
  - The array contents are not cleared.

## Configuration

- `MEM_SKY130_RMW_EN` defined: partial writes are supported as above.
- Not defined:
  - `bwe` is ignored and every write is a full single-cycle write.
  - The FSM is not built and `ready` is constant 1 after reset.
  - The read latency is unchanged.

## Test plan

- Reset, then read `addr 0..3` of `DATA_BIT=64, DEPTH=300`: `rdata=0`. The pre-written pattern `0xA5A5_0000_0000_0000 + addr` returns 2 cycles after each accept, with `rvalid` on 4 consecutive cycles.
- Full write `addr 130 = 0xDEADBEEF_CAFEF00D`, then read 130 and 2. Address 130 returns the written value. Address 2 (tile 0) is unchanged, which checks the tile decode.
- With RMW enabled: write `0xFFFF_FFFF_FFFF_FFFF` to `addr 5`, then partial write `wdata=0`, `bwe=0x0000_00FF_0000_FF00`. `ready` is low for 2 cycles, and a read of 5 returns `0xFFFF_FF00_FFFF_00FF`.
- `wen=ren=1` at `addr 7` with `wdata=0x1234`: no `rvalid`. A later read returns `0x1234`. Out-of-range `addr 300` write is dropped, and a read of 300 returns 0 with `rvalid`.
- Assert `rst` in `MERGE` of a partial write to `addr 9` (old value `0x55`):
  - After reset, `ready=1` and `rvalid=0`.
  - A read of 9 returns `0x55`.
- Compile without `MEM_SKY130_RMW_EN`:
  - A partial-mask write of `0x00AB` writes all bits.
  - `ready` never drops.
